// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU between
// two requesters, with registered operands and a registered valid/ready result.
module alu_share_arbiter #(
    parameter int BW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [BW-1:0] req0_d1,
    input  logic [BW-1:0] req0_d2,
    input  logic [3:0]    req0_choice,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [BW-1:0] req1_d1,
    input  logic [BW-1:0] req1_d2,
    input  logic [3:0]    req1_choice,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [BW-1:0] rsp_result,
    output logic [BW-1:0] alu_d1,
    output logic [BW-1:0] alu_d2,
    output logic [3:0]    alu_choice,
    input  logic [BW-1:0] alu_result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic          last_grant;
    logic          tag;
    logic [BW-1:0] op_d1;
    logic [BW-1:0] op_d2;
    logic [3:0]    op_choice;
    logic [BW-1:0] result;
    logic          gnt0;
    logic          gnt1;

    // On contention the port that did not win last time is served.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant;
                gnt1 = ~last_grant;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            tag        <= 1'b0;
            op_d1      <= '0;
            op_d2      <= '0;
            op_choice  <= '0;
            result     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        op_d1      <= gnt1 ? req1_d1 : req0_d1;
                        op_d2      <= gnt1 ? req1_d2 : req0_d2;
                        op_choice  <= gnt1 ? req1_choice : req0_choice;
                        tag        <= gnt1;
                        last_grant <= gnt1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result <= alu_result;
                    state  <= RESP;
                end
                RESP: begin
                    if (tag ? rsp1_ready : rsp0_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp0_valid = (state == RESP) && !tag;
    assign rsp1_valid = (state == RESP) && tag;
    assign rsp_result = result;
    assign alu_d1     = op_d1;
    assign alu_d2     = op_d2;
    assign alu_choice = op_choice;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a small behavioural ALU sits on the
// alu_* side; expected results are hand-computed constants.
module tb_alu_share_arbiter;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_SLL = 4'h2;
    localparam logic [3:0] OP_SLT = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_d1, req0_d2, req1_d1, req1_d2;
    logic [3:0]  req0_choice, req1_choice;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result, alu_d1, alu_d2, alu_result;
    logic [3:0]  alu_choice;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.BW(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_d1(req0_d1), .req0_d2(req0_d2), .req0_choice(req0_choice),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_d1(req1_d1), .req1_d2(req1_d2), .req1_choice(req1_choice),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result),
        .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_choice(alu_choice),
        .alu_result(alu_result)
    );

    // External shared ALU; undefined opcodes return 0.
    always_comb begin
        case (alu_choice)
            OP_ADD:  alu_result = alu_d1 + alu_d2;
            OP_SUB:  alu_result = alu_d1 - alu_d2;
            OP_SLL:  alu_result = alu_d1 << alu_d2[4:0];
            OP_SLT:  alu_result = {31'd0, $signed(alu_d1) < $signed(alu_d2)};
            OP_XOR:  alu_result = alu_d1 ^ alu_d2;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        int          port;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  choice;
        logic [31:0] exp;
        int          stall;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int p, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] c);
        if (p == 0) begin
            req0_valid = v; req0_d1 = a; req0_d2 = b; req0_choice = c;
        end else begin
            req1_valid = v; req1_d1 = a; req1_d2 = b; req1_choice = c;
        end
    endtask

    task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic [31:0] exp, input int stall);
        drive_req(p, 1'b1, a, b, c);
        #1;
        chk("accept_ready", (p == 1) ? req1_ready : req0_ready, 1);
        chk("other_ready", (p == 1) ? req0_ready : req1_ready, 0);
        @(posedge clk); #1;
        // Payload is scrambled after accept; the captured copy must persist.
        drive_req(p, 1'b0, ~a, ~b, c);
        #1;
        chk("exec_readies", {req0_ready, req1_ready}, 0);
        chk("exec_rsp_valids", {rsp0_valid, rsp1_valid}, 0);
        chk("exec_alu_d1", alu_d1, a);
        chk("exec_alu_d2", alu_d2, b);
        chk("exec_alu_choice", alu_choice, c);
        @(posedge clk); #1;
        for (int s = 0; s <= stall; s++) begin
            if (s == stall) begin
                if (p == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
            end
            chk("resp_valid", (p == 1) ? rsp1_valid : rsp0_valid, 1);
            chk("resp_other_valid", (p == 1) ? rsp0_valid : rsp1_valid, 0);
            chk("resp_result", rsp_result, exp);
            chk("resp_alu_d1", alu_d1, a);
            if (s < stall) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk("after_resp_valids", {rsp0_valid, rsp1_valid}, 0);
    endtask

    initial begin
        int k;
        int r0;
        int r1;

        vecs[0] = '{0, 32'd5,          32'd7,  OP_ADD, 32'd12,         0};
        vecs[1] = '{1, 32'd1,          32'd4,  OP_SLL, 32'd16,         2};
        vecs[2] = '{0, 32'hFFFF_FFFF,  32'd1,  OP_SLT, 32'd1,          0};
        vecs[3] = '{0, 32'd3,          32'd4,  4'hF,   32'd0,          1};
        vecs[4] = '{1, 32'd10,         32'd3,  OP_SUB, 32'd7,          0};
        vecs[5] = '{1, 32'h0000_00F0,  32'h0F, OP_XOR, 32'h0000_00FF,  0};
        vecs[6] = '{0, 32'd0,          32'd1,  OP_SUB, 32'hFFFF_FFFF,  0};

        rst = 1'b1;
        drive_req(0, 1'b0, '0, '0, '0);
        drive_req(1, 1'b0, '0, '0, '0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_readies", {req0_ready, req1_ready}, 0);
        chk("reset_rsp_valids", {rsp0_valid, rsp1_valid}, 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_alu_d1", alu_d1, 0);
        chk("reset_alu_d2", alu_d2, 0);
        chk("reset_alu_choice", alu_choice, 0);
        rst = 1'b0;
        #1;

        // Contention from reset: both valid back to back, strict alternation.
        drive_req(0, 1'b1, 32'd10, 32'd3, OP_SUB);
        drive_req(1, 1'b1, 32'hF0, 32'h0F, OP_XOR);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        k = 0; r0 = 0; r1 = 0;
        for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
            if (req0_ready || req1_ready) begin
                chk("contend_one_ready", req0_ready & req1_ready, 0);
                chk("contend_order", req1_ready, k % 2);
                k++;
            end
            if (rsp0_valid) begin chk("contend_rsp0", rsp_result, 32'd7); r0++; end
            if (rsp1_valid) begin chk("contend_rsp1", rsp_result, 32'hFF); r1++; end
            @(posedge clk); #2;
        end
        chk("contend_grants", k, 8);
        drive_req(0, 1'b0, '0, '0, '0);
        drive_req(1, 1'b0, '0, '0, '0);
        for (int cyc = 0; cyc < 3; cyc++) begin
            if (rsp0_valid) begin chk("contend_rsp0", rsp_result, 32'd7); r0++; end
            if (rsp1_valid) begin chk("contend_rsp1", rsp_result, 32'hFF); r1++; end
            @(posedge clk); #2;
        end
        chk("contend_rsp0_count", r0, 4);
        chk("contend_rsp1_count", r1, 4);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].port, vecs[i].d1, vecs[i].d2, vecs[i].choice, vecs[i].exp, vecs[i].stall);
        end

        // Backpressure on port 1 while port 0 waits.
        drive_req(1, 1'b1, 32'd1, 32'd4, OP_SLL);
        #1;
        chk("bp_accept1", req1_ready, 1);
        @(posedge clk); #1;
        drive_req(1, 1'b0, '0, '0, '0);
        drive_req(0, 1'b1, 32'd2, 32'd3, OP_ADD);
        #1;
        chk("bp_exec_ready0", req0_ready, 0);
        @(posedge clk); #1;
        for (int s = 0; s < 5; s++) begin
            chk("bp_rsp1_valid", rsp1_valid, 1);
            chk("bp_rsp0_valid", rsp0_valid, 0);
            chk("bp_result", rsp_result, 32'd16);
            chk("bp_ready0", req0_ready, 0);
            @(posedge clk); #1;
        end
        rsp1_ready = 1'b1;
        #1;
        chk("bp_release_ready0", req0_ready, 0);
        @(posedge clk); #1;
        rsp1_ready = 1'b0;
        chk("bp_idle_rsp1", rsp1_valid, 0);
        chk("bp_idle_ready0", req0_ready, 1);
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0, '0);
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_rsp0_valid", rsp0_valid, 1);
        chk("bp_rsp0_result", rsp_result, 32'd5);
        @(posedge clk); #1;
        rsp0_ready = 1'b0;

        // Reset during EXEC discards the operation.
        drive_req(0, 1'b1, 32'd1, 32'd1, OP_ADD);
        #1;
        chk("rst_accept", req0_ready, 1);
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rsp0_ready = 1'b1;
        chk("rst_readies", {req0_ready, req1_ready}, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_alu_d1", alu_d1, 0);
        chk("rst_alu_d2", alu_d2, 0);
        chk("rst_alu_choice", alu_choice, 0);
        for (int s = 0; s < 4; s++) begin
            chk("rst_no_rsp", {rsp0_valid, rsp1_valid}, 0);
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b0;
        run_op(1, 32'd6, 32'd4, OP_XOR, 32'd2, 0);
        drive_req(0, 1'b1, 32'd8, 32'd1, OP_ADD);
        drive_req(1, 1'b1, 32'd8, 32'd1, OP_SUB);
        #1;
        chk("rst_contend_ready0", req0_ready, 1);
        chk("rst_contend_ready1", req1_ready, 0);
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0, '0);
        drive_req(1, 1'b0, '0, '0, '0);
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_contend_rsp0", rsp0_valid, 1);
        chk("rst_contend_result", rsp_result, 32'd9);
        @(posedge clk); #1;
        rsp0_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
